// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the run controller and the LED/peek display mux.
package cpu_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_RUN  = 3'd2,
    ST_HALT = 3'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_DONE  = 2'd1,
    CAUSE_BP    = 2'd2,
    CAUSE_LIMIT = 2'd3
  } cause_t;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Board-side controls, core-side status and display outputs of the run controller.
interface cpu_run_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             step_tick;
  logic             run_req;
  logic             restart;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  cpu_pc;
  logic             cpu_done;
  logic [CNT_W-1:0] cycle_limit;
  logic             cpu_en;
  logic             cpu_reset;
  logic [2:0]       state;
  logic [1:0]       stop_cause;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output step_tick, run_req, restart, bp_en, bp_addr, cpu_pc, cpu_done, cycle_limit,
    input  cpu_en, cpu_reset, state, stop_cause, instr_count
  );

  modport slave (
    input  step_tick, run_req, restart, bp_en, bp_addr, cpu_pc, cpu_done, cycle_limit,
    output cpu_en, cpu_reset, state, stop_cause, instr_count
  );
endinterface

// File: rtl/cpu_run_ctrl_pacer.sv
// Free-run prescaler: counts 0..RUN_PERIOD-1 while clr is low, tick high at terminal count.
module run_pacer #(
  parameter int RUN_PERIOD = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int W = (RUN_PERIOD > 2) ? $clog2(RUN_PERIOD) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(RUN_PERIOD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                 cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/cpu_run_ctrl.sv
// Gates the single-cycle core with one-clk enable pulses: step, paced run, breakpoint,
// cycle budget and done detection; pulse and counter update land in the same cycle.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int CNT_W      = 32,
  parameter int RUN_PERIOD = 12500000,
  parameter int RST_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset,
  cpu_run_ctrl_if.slave  bus
);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t           st, st_nx;
  cause_t           cause, cause_nx;
  logic [RW-1:0]    rst_cnt;
  logic [CNT_W-1:0] cnt;
  logic             run_q, run_rise, tick;
  logic             cpu_en_q, pulse, step_ok;
  logic             bp_skip, bp_skip_nx;
  logic             bp_hit, lim_hit, resumable;

  run_pacer #(.RUN_PERIOD(RUN_PERIOD)) u_pacer (
    .clk   (clk),
    .reset (reset),
    .clr   (st != ST_RUN),
    .tick  (tick)
  );

  assign run_rise  = bus.run_req & ~run_q;
  // a step arriving right behind a pulse is dropped so enables never abut
  assign step_ok   = bus.step_tick & ~cpu_en_q;
  assign bp_hit    = bus.bp_en && (bus.cpu_pc == bus.bp_addr) && !bp_skip;
  assign lim_hit   = (bus.cycle_limit != '0) && (cnt >= bus.cycle_limit);
  assign resumable = (cause == CAUSE_BP) || (cause == CAUSE_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= ST_INIT;
    else        st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    if (bus.restart) begin
      st_nx = ST_INIT;
    end else begin
      case (st)
        ST_INIT: if (rst_cnt == RW'(RST_CYCLES - 1)) st_nx = ST_IDLE;
        ST_IDLE: if (run_rise) st_nx = ST_RUN;
        ST_RUN: begin
          if (!bus.run_req)                                  st_nx = ST_IDLE;
          else if (tick && (bus.cpu_done || bp_hit || lim_hit)) st_nx = ST_HALT;
        end
        ST_HALT: if (run_rise && resumable) st_nx = ST_RUN;
        default: st_nx = ST_INIT;
      endcase
    end
  end

  always_comb begin
    pulse      = 1'b0;
    cause_nx   = cause;
    bp_skip_nx = bp_skip;
    if (bus.restart) begin
      cause_nx   = CAUSE_NONE;
      bp_skip_nx = 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (run_rise)                         cause_nx = CAUSE_NONE;
          else if (step_ok && !bus.cpu_done)    pulse    = 1'b1;
        end
        ST_RUN: begin
          if (bus.run_req && tick) begin
            if (bus.cpu_done)  cause_nx = CAUSE_DONE;
            else if (bp_hit)   cause_nx = CAUSE_BP;
            else if (lim_hit)  cause_nx = CAUSE_LIMIT;
            else               pulse    = 1'b1;
          end
        end
        ST_HALT: begin
          if (resumable) begin
            if (run_rise) begin
              cause_nx = CAUSE_NONE;
              // let the instruction sitting on the breakpoint execute once
              if (cause == CAUSE_BP) bp_skip_nx = 1'b1;
            end else if (step_ok) begin
              pulse = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    if (pulse) bp_skip_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_cnt  <= '0;
      run_q    <= 1'b0;
      cpu_en_q <= 1'b0;
      cnt      <= '0;
      cause    <= CAUSE_NONE;
      bp_skip  <= 1'b0;
    end else begin
      rst_cnt  <= (st == ST_INIT && st_nx == ST_INIT) ? rst_cnt + 1'b1 : '0;
      run_q    <= bus.run_req;
      cpu_en_q <= pulse;
      cause    <= cause_nx;
      bp_skip  <= bp_skip_nx;
      if (bus.restart)               cnt <= '0;
      else if (pulse && cnt != '1)   cnt <= cnt + 1'b1;
    end
  end

  assign bus.cpu_en      = cpu_en_q;
  assign bus.cpu_reset   = (st == ST_INIT);
  assign bus.state       = st;
  assign bus.stop_cause  = cause;
  assign bus.instr_count = cnt;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a tiny core model advancing the PC on each enable.
module tb_cpu_run_ctrl;
  logic clk = 1'b0;
  logic reset;

  cpu_run_ctrl_if #(.PC_W(32), .CNT_W(8)) bus ();

  cpu_run_ctrl #(.PC_W(32), .CNT_W(8), .RUN_PERIOD(4), .RST_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  int   total = 0, passed = 0;
  int   pulses = 0, viol = 0;
  logic prev_en = 1'b0;

  // core model and invariant monitor, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (bus.cpu_en && (prev_en || bus.cpu_reset)) viol++;
    if (bus.cpu_en) begin
      pulses++;
      bus.cpu_pc = bus.cpu_pc + 32'd4;
    end
    prev_en = bus.cpu_en;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_step();
    bus.step_tick = 1'b1;
    cyc(1);
    bus.step_tick = 1'b0;
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    bus.cpu_pc  = 32'd0;
    cyc(1);
    bus.restart = 1'b0;
    cyc(5);
  endtask

  initial begin
    int          rc, p0;
    logic [15:0] mask;

    reset = 1'b0;
    bus.step_tick = 1'b0; bus.run_req = 1'b0; bus.restart = 1'b0;
    bus.bp_en = 1'b0; bus.bp_addr = 32'h0C; bus.cpu_pc = 32'd0;
    bus.cpu_done = 1'b0; bus.cycle_limit = 8'd0;
    cyc(3);
    chk("rst_state", bus.state, 0);
    chk("rst_cpu_reset", bus.cpu_reset, 1);
    chk("rst_cpu_en", bus.cpu_en, 0);
    chk("rst_count", bus.instr_count, 0);
    chk("rst_cause", bus.stop_cause, 0);

    reset = 1'b1;
    rc = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.cpu_reset) rc++;
      cyc(1);
    end
    chk("init_len", rc, 4);
    chk("init_to_idle", bus.state, 1);
    chk("init_no_pulse", pulses, 0);

    // single steps in IDLE
    for (int i = 0; i < 3; i++) begin
      do_step();
      chk("step_en", bus.cpu_en, 1);
      cyc(10);
    end
    chk("step_pulses", pulses, 3);
    chk("step_count", bus.instr_count, 3);

    // paced run, dropped before the third pulse
    p0 = pulses;
    mask = '0;
    bus.run_req = 1'b1;
    cyc(1);
    for (int k = 1; k <= 14; k++) begin
      cyc(1);
      mask[k] = bus.cpu_en;
      if (k == 9) bus.run_req = 1'b0;
    end
    chk("run_pulse_map", mask, 16'h0110);
    chk("run_pause_state", bus.state, 1);
    chk("run_count", bus.instr_count, 5);

    // breakpoint at 0x0C, then resume across it
    do_restart();
    chk("restart_count", bus.instr_count, 0);
    chk("restart_idle", bus.state, 1);
    p0 = pulses;
    bus.bp_en = 1'b1;
    bus.run_req = 1'b1;
    cyc(20);
    chk("bp_state", bus.state, 3);
    chk("bp_cause", bus.stop_cause, 2);
    chk("bp_pc", bus.cpu_pc, 32'h0C);
    chk("bp_pulses", pulses - p0, 3);
    bus.run_req = 1'b0;
    cyc(2);
    bus.run_req = 1'b1;
    cyc(1);
    cyc(5);
    chk("bp_resume_pc", bus.cpu_pc, 32'h10);
    chk("bp_resume_state", bus.state, 2);
    cyc(4);
    chk("bp_keeps_running", bus.cpu_pc, 32'h14);
    bus.run_req = 1'b0;
    bus.bp_en = 1'b0;
    cyc(2);

    // cycle budget
    do_restart();
    p0 = pulses;
    bus.cycle_limit = 8'd5;
    bus.run_req = 1'b1;
    cyc(40);
    chk("lim_pulses", pulses - p0, 5);
    chk("lim_state", bus.state, 3);
    chk("lim_cause", bus.stop_cause, 3);
    chk("lim_count", bus.instr_count, 5);
    do_step();
    chk("lim_step_en", bus.cpu_en, 1);
    cyc(3);
    chk("lim_step_count", bus.instr_count, 6);
    chk("lim_step_state", bus.state, 3);
    p0 = pulses;
    bus.run_req = 1'b0;
    cyc(2);
    bus.run_req = 1'b1;
    cyc(12);
    chk("lim_retrip_pulses", pulses - p0, 0);
    chk("lim_retrip_cause", bus.stop_cause, 3);

    // done detection during RUN, then everything but restart is ignored
    bus.cycle_limit = 8'd0;
    bus.run_req = 1'b0;
    cyc(2);
    p0 = pulses;
    bus.run_req = 1'b1;
    cyc(3);
    bus.cpu_done = 1'b1;
    cyc(8);
    chk("done_state", bus.state, 3);
    chk("done_cause", bus.stop_cause, 1);
    do_step();
    cyc(3);
    bus.run_req = 1'b0;
    cyc(2);
    bus.run_req = 1'b1;
    cyc(10);
    bus.cpu_done = 1'b0;
    do_step();
    cyc(3);
    chk("done_no_pulses", pulses - p0, 0);
    chk("done_sticky", bus.stop_cause, 1);

    // restart coincident with step_tick while running
    do_restart();
    bus.run_req = 1'b0;
    cyc(1);
    bus.run_req = 1'b1;
    cyc(7);
    chk("rr_running", bus.state, 2);
    chk("rr_count_pre", bus.instr_count, 1);
    p0 = pulses;
    bus.restart = 1'b1;
    bus.step_tick = 1'b1;
    cyc(1);
    bus.restart = 1'b0;
    bus.step_tick = 1'b0;
    chk("rr_state", bus.state, 0);
    chk("rr_count", bus.instr_count, 0);
    rc = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.cpu_reset) rc++;
      cyc(1);
    end
    chk("rr_reset_len", rc, 4);
    chk("rr_no_pulse", pulses - p0, 0);
    chk("rr_idle", bus.state, 1);

    // counter saturation
    bus.run_req = 1'b0;
    cyc(1);
    bus.run_req = 1'b1;
    cyc(265 * 4 + 10);
    chk("sat_count", bus.instr_count, 8'hFF);
    chk("sat_running", bus.state, 2);
    chk("invariants", viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Execution controller between the board I/O (debounced step button, run switch) and the MIPS single-cycle core.
- Runs on the fast board clock and gates the core with a one-cycle clock-enable pulse per instruction, replacing the free cycle_generator.
- Supports single-step, paced free-run, PC breakpoint, cycle budget and done-detection.
- Exposes state, stop cause and executed-instruction count for the LED/peek display.

Parameters:
- PC_W, 32, width of PC and breakpoint address
- CNT_W, 32, width of instruction counter and cycle limit
- RUN_PERIOD, 12500000, clk cycles between enable pulses in run mode; must be >= 2
- RST_CYCLES, 4, clk cycles the core is held in reset after controller reset or restart

Ports:
- clk  input  1  board clock
- reset  input  1  asynchronous, active-low controller reset
- step_tick  input  1  one-clk pulse from debouncer: execute one instruction
- run_req  input  1  level; rising edge starts free-run, low pauses
- restart  input  1  one-clk pulse: re-enter INIT (core reset, counter clear)
- bp_en  input  1  breakpoint enable
- bp_addr  input  PC_W  breakpoint PC
- cpu_pc  input  PC_W  current core PC
- cpu_done  input  1  core done flag
- cycle_limit  input  CNT_W  max instructions per run; 0 = unlimited
- cpu_en  output  1  one-clk enable; core advances one instruction on the clk edge where it is high
- cpu_reset  output  1  active-high reset to core
- state  output  3  0 INIT, 1 IDLE, 2 RUN, 3 HALT
- stop_cause  output  2  0 none, 1 done, 2 breakpoint, 3 limit
- instr_count  output  CNT_W  instructions executed since INIT

Behaviour:
- Reset (async, reset=0): state=INIT, cpu_reset=1, cpu_en=0, instr_count=0, stop_cause=0, prescaler=0, bp_skip=0, run_req edge register=0.
- INIT: cpu_reset=1 for exactly RST_CYCLES clk cycles; then go to IDLE, cpu_reset=0. step_tick and run_req are ignored during INIT.
- IDLE:
  - step_tick: cpu_en=1 for the next cycle. The breakpoint is not checked. instr_count++ in the same cycle as cpu_en.
  - run_req rising edge: enter RUN with prescaler=0, stop_cause=0.
  - If both happen in the same cycle, run wins and the step is dropped.
- RUN:
  - The prescaler counts 0..RUN_PERIOD-1. At terminal count, evaluate in priority order:
    - (a) cpu_done=1 -> HALT, cause 1.
    - (b) bp_en && cpu_pc==bp_addr && !bp_skip -> HALT, cause 2, no pulse.
    - (c) cycle_limit!=0 && instr_count>=cycle_limit -> HALT, cause 3.
    - (d) otherwise issue cpu_en, instr_count++, bp_skip=0.
  - run_req=0 -> IDLE immediately, prescaler cleared, no pulse that cycle.
  - step_tick is ignored in RUN.
- HALT:
  - No cpu_en. stop_cause holds.
  - cause 2: a run_req rising edge (after it has been low) re-enters RUN with bp_skip=1, so the breakpoint instruction executes once. step_tick executes one instruction, sets bp_skip=0, stays in HALT (cause kept).
  - cause 3: step_tick single-steps. A run rising edge re-enters RUN; the limit re-trips immediately unless cycle_limit was raised.
  - cause 1: step_tick and run_req are ignored. Leave only via restart or reset.
- In IDLE, step_tick while cpu_done=1 produces no pulse.
- restart in any state -> INIT, instr_count=0, stop_cause=0, bp_skip=0. Restart has priority over every other event in the same cycle.
- cpu_en is never high in two consecutive cycles. cpu_en and cpu_reset are never high together.
- instr_count saturates at all-ones, no wrap.
- Run-mode latency: the first pulse occurs RUN_PERIOD cycles after the rising-edge sample.

Decomposition:
- Shared package holds the state encoding constants (ST_INIT..ST_HALT) and the stop-cause constants (CAUSE_NONE/DONE/BP/LIMIT), reused by the display mux.
- One sub-module, run_pacer: the prescaler counter with clear input, producing a terminal-count tick.
- The FSM, edge detect and counter live in cpu_run_ctrl.

Test Plan:
- Reset low 3 cycles then high -> cpu_reset=1 for 4 cycles, state=1 afterwards, cpu_en never asserted.
- IDLE, three step_tick pulses 10 cycles apart -> exactly 3 single-cycle cpu_en pulses, instr_count=3.
- RUN_PERIOD=4, run_req 0->1 -> cpu_en on cycles 4, 8, 12 after the edge. Drop run_req at cycle 9 -> state=1, no pulse at 12.
- bp_en=1, bp_addr=0x0C, cpu_pc stepping 0x00, 0x04, … -> HALT cause 2 with cpu_pc=0x0C and no pulse. Run re-edge -> one pulse, pc 0x10, continues running.
- cycle_limit=5, run -> exactly 5 pulses, HALT cause 3, instr_count=5. cpu_done=1 during RUN -> HALT cause 1; subsequent step_tick and run edges produce 0 pulses.
- restart pulse in RUN coincident with step_tick -> state=INIT, instr_count=0, cpu_reset=1 for 4 cycles, no cpu_en.
